// File: rtl/fp_addsub_pipe.sv
// Streaming floating-point adder/subtractor: input register, align, add, normalize, round/pack.
// One operand pair per cycle; result and flags appear four edges after in_valid is sampled.
module fp_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  output logic [W-1:0] result,
  output logic         over,
  output logic         under,
  output logic         invalid,
  output logic         inexact
);
  localparam int FW   = MAN_W + 4;          // {hidden, frac, guard, round, sticky}
  localparam int LZ_W = $clog2(FW);
  localparam int XW   = EXP_W + LZ_W + 2;   // signed exponent, room for normalize underflow
  localparam int RW   = MAN_W + 2;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  // ---------------- stage 0: input register ----------------
  logic         s0_valid, s0_sub;
  logic [W-1:0] s0_a, s0_b;

  logic                s1_valid, s1_sign, s1_eff_sub, s1_spec, s1_inv;
  logic [EXP_W-1:0]    s1_exp;
  logic [FW-1:0]       s1_big, s1_small;
  logic [W-1:0]        s1_spec_res;

  logic                s2_valid, s2_sign, s2_eff_sub, s2_spec, s2_inv;
  logic [EXP_W-1:0]    s2_exp;
  logic [FW:0]         s2_sum;
  logic [W-1:0]        s2_spec_res;

  logic                s3_valid, s3_sign, s3_zero, s3_spec, s3_inv;
  logic signed [XW-1:0] s3_exp;
  logic [FW-1:0]       s3_man;
  logic [W-1:0]        s3_spec_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s0_valid <= in_valid;
      s1_valid <= s0_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide what is meaningful.
  always_ff @(posedge clk) begin
    s0_a   <= a;
    s0_b   <= b;
    s0_sub <= sub;
  end

  // ---------------- stage 1: unpack, classify, swap, align ----------------
  logic             sa, sb, a_inf, b_inf, a_nan, b_nan, a_big, big_s;
  logic [EXP_W-1:0] ea, eb, big_e, small_e, shift;
  logic [W-2:0]     mag_a, mag_b;
  logic [MAN_W:0]   man_a, man_b, big_m, small_m;
  logic [FW-1:0]    small_ext, aligned;
  logic [2*FW-1:0]  wide;
  logic             spec1, inv1;
  logic [W-1:0]     spec_res1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sa        = s0_a[W-1];
    sb        = s0_b[W-1] ^ s0_sub;
    ea        = s0_a[W-2:MAN_W];
    eb        = s0_b[W-2:MAN_W];
    a_inf     = (ea == EXP_MAX) && (s0_a[MAN_W-1:0] == '0);
    b_inf     = (eb == EXP_MAX) && (s0_b[MAN_W-1:0] == '0);
    a_nan     = (ea == EXP_MAX) && (s0_a[MAN_W-1:0] != '0);
    b_nan     = (eb == EXP_MAX) && (s0_b[MAN_W-1:0] != '0);
    spec1     = a_inf | b_inf | a_nan | b_nan;
    inv1      = 1'b0;
    spec_res1 = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) inv1 = 1'b1;
    else if (a_inf) spec_res1 = {sa, EXP_MAX, {MAN_W{1'b0}}};
    else if (b_inf) spec_res1 = {sb, EXP_MAX, {MAN_W{1'b0}}};

    // Exponent zero flushes to zero, so subnormal fraction bits never reach the datapath.
    mag_a = (ea == '0) ? '0 : s0_a[W-2:0];
    mag_b = (eb == '0) ? '0 : s0_b[W-2:0];
    man_a = (ea == '0) ? '0 : {1'b1, s0_a[MAN_W-1:0]};
    man_b = (eb == '0) ? '0 : {1'b1, s0_b[MAN_W-1:0]};
    a_big = (mag_a >= mag_b);
    big_s   = a_big ? sa : sb;
    big_e   = a_big ? ea : eb;
    big_m   = a_big ? man_a : man_b;
    small_e = a_big ? eb : ea;
    small_m = a_big ? man_b : man_a;

    shift     = big_e - small_e;
    small_ext = {small_m, 3'b000};
    wide      = {small_ext, {FW{1'b0}}} >> shift;
    if (int'(shift) >= FW) aligned = {{(FW-1){1'b0}}, |small_ext};
    else                   aligned = {wide[2*FW-1:FW+1], wide[FW] | (|wide[FW-1:0])};
  end

  always_ff @(posedge clk) begin
    s1_sign     <= big_s;
    s1_exp      <= big_e;
    s1_big      <= {big_m, 3'b000};
    s1_small    <= aligned;
    s1_eff_sub  <= sa ^ sb;
    s1_spec     <= spec1;
    s1_inv      <= inv1;
    s1_spec_res <= spec_res1;
  end

  // ---------------- stage 2: magnitude add/subtract ----------------
  always_ff @(posedge clk) begin
    s2_sum      <= s1_eff_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                              : ({1'b0, s1_big} + {1'b0, s1_small});
    s2_sign     <= s1_sign;
    s2_exp      <= s1_exp;
    s2_eff_sub  <= s1_eff_sub;
    s2_spec     <= s1_spec;
    s2_inv      <= s1_inv;
    s2_spec_res <= s1_spec_res;
  end

  // ---------------- stage 3: normalize ----------------
  logic [LZ_W-1:0]      lzc;
  logic [FW-1:0]        norm_m;
  logic signed [XW-1:0] norm_e;
  logic                 zero3;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < FW; i++) begin
      if (s2_sum[i]) lzc = LZ_W'(FW - 1 - i);
    end
    zero3 = (s2_sum == '0);
    if (s2_sum[FW]) begin
      norm_m = {s2_sum[FW:2], s2_sum[1] | s2_sum[0]};
      norm_e = $signed(XW'(s2_exp) + XW'(1));
    end else begin
      norm_m = s2_sum[FW-1:0] << lzc;
      norm_e = $signed(XW'(s2_exp) - XW'(lzc));
    end
  end

  always_ff @(posedge clk) begin
    s3_man      <= norm_m;
    s3_exp      <= norm_e;
    s3_zero     <= zero3;
    // Exact cancellation yields +0; adding like-signed zeros keeps their sign.
    s3_sign     <= (zero3 && s2_eff_sub) ? 1'b0 : s2_sign;
    s3_spec     <= s2_spec;
    s3_inv      <= s2_inv;
    s3_spec_res <= s2_spec_res;
  end

  // ---------------- stage 4: round to nearest even, pack, flags ----------------
  logic [RW-1:0]        rnd;
  logic signed [XW-1:0] e4;
  logic                 rnd_up;
  logic [W-1:0]         res4;
  logic                 over4, under4, inv4, inx4;

  always_comb begin
    rnd_up = s3_man[2] & (s3_man[1] | s3_man[0] | s3_man[3]);
    rnd    = {1'b0, s3_man[FW-1:3]} + RW'(rnd_up);
    e4     = $signed(s3_exp + XW'(rnd[RW-1]));
    res4   = {s3_sign, e4[EXP_W-1:0], rnd[RW-1] ? {MAN_W{1'b0}} : rnd[MAN_W-1:0]};
    over4  = 1'b0;
    under4 = 1'b0;
    inv4   = 1'b0;
    inx4   = |s3_man[2:0];
    if (s3_spec) begin
      res4 = s3_spec_res;
      inv4 = s3_inv;
      inx4 = 1'b0;
    end else if (s3_zero) begin
      res4 = {s3_sign, {(W-1){1'b0}}};
      inx4 = 1'b0;
    end else if (e4 >= $signed(XW'(EXP_MAX))) begin
      res4  = {s3_sign, EXP_MAX, {MAN_W{1'b0}}};
      over4 = 1'b1;
      inx4  = 1'b1;
    end else if (e4 <= $signed(XW'(0))) begin
      res4   = {s3_sign, {(W-1){1'b0}}};
      under4 = 1'b1;
      inx4   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      over      <= 1'b0;
      under     <= 1'b0;
      invalid   <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        result  <= res4;
        over    <= over4;
        under   <= under4;
        invalid <= inv4;
        inexact <= inx4;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe: half- and single-precision instances, directed
// cases plus random traffic scored against an exact big-integer reference model.
module tb_fp_addsub_pipe;
  typedef logic [383:0] big_t;
  typedef struct {
    logic [63:0] res;
    logic        ov, un, inv, inx;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        iv16 = 1'b0, sub16 = 1'b0, iv32 = 1'b0, sub32 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic        ov16, v16, ovf16, un16, inv16, inx16;
  logic        v32, ovf32, un32, inv32, inx32;

  fp_addsub_pipe dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .a(a16), .b(b16), .sub(sub16),
    .out_valid(v16), .result(res16), .over(ovf16), .under(un16),
    .invalid(inv16), .inexact(inx16)
  );

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .a(a32), .b(b32), .sub(sub32),
    .out_valid(v32), .result(res32), .over(ovf32), .under(un32),
    .invalid(inv32), .inexact(inx32)
  );

  exp_t q16[$], q32[$];
  exp_t last16 = '{default: 0}, last32 = '{default: 0};
  int   n_assert = 0, n_fail = 0, cycle = 0;

  // Exact reference: both operands scaled to a common integer grid, summed exactly,
  // then rounded to MAN_W+1 significant bits (ties to even) at unbounded exponent.
  function automatic exp_t ref_fp(input int ew, input int mw, input logic [63:0] a,
                                  input logic [63:0] b, input logic sub);
    exp_t   r;
    longint emax, fmask, ea, eb, fa, fb, e;
    logic   sa, sb, sign;
    bit     nan_a, nan_b, inf_a, inf_b;
    big_t   x, y, mag, q, rem, half;
    int     p, k;
    r     = '{default: 0};
    emax  = (longint'(1) << ew) - 1;
    fmask = (longint'(1) << mw) - 1;
    sa    = a[ew+mw];
    sb    = b[ew+mw] ^ sub;
    ea    = longint'(a >> mw) & emax;
    eb    = longint'(b >> mw) & emax;
    fa    = longint'(a) & fmask;
    fb    = longint'(b) & fmask;
    nan_a = (ea == emax) && (fa != 0);
    nan_b = (eb == emax) && (fb != 0);
    inf_a = (ea == emax) && (fa == 0);
    inf_b = (eb == emax) && (fb == 0);
    if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) begin
      r.res = (emax << mw) | (longint'(1) << (mw - 1));
      r.inv = 1'b1;
      return r;
    end
    if (inf_a) begin r.res = (longint'(sa) << (ew + mw)) | (emax << mw); return r; end
    if (inf_b) begin r.res = (longint'(sb) << (ew + mw)) | (emax << mw); return r; end
    x = (ea == 0) ? '0 : (big_t'((longint'(1) << mw) | fa) << (ea - 1));
    y = (eb == 0) ? '0 : (big_t'((longint'(1) << mw) | fb) << (eb - 1));
    if (sa == sb)   begin mag = x + y; sign = sa;   end
    else if (x > y) begin mag = x - y; sign = sa;   end
    else if (y > x) begin mag = y - x; sign = sb;   end
    else            begin mag = '0;    sign = 1'b0; end
    if (mag == '0) begin
      r.res = longint'(sign) << (ew + mw);
      return r;
    end
    p = 0;
    for (int i = 0; i < $bits(big_t); i++) if (mag[i]) p = i;
    k = p - mw;
    e = p - mw + 1;
    if (k > 0) begin
      q    = mag >> k;
      rem  = mag - (q << k);
      half = big_t'(1) << (k - 1);
      r.inx = (rem != '0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = mag << (-k);
    end
    if (q[mw+1]) begin q = q >> 1; e = e + 1; end
    if (e >= emax) begin
      r.res = (longint'(sign) << (ew + mw)) | (emax << mw);
      r.ov  = 1'b1;
      r.inx = 1'b1;
    end else if (e <= 0) begin
      r.res = longint'(sign) << (ew + mw);
      r.un  = 1'b1;
      r.inx = 1'b1;
    end else begin
      r.res = (longint'(sign) << (ew + mw)) | (e << mw) | (longint'(q[63:0]) & fmask);
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [63:0] res, input logic ov, input logic un,
                              input logic inv, input logic inx);
    exp_t r;
    r     = '{default: 0};
    r.res = res;
    r.ov  = ov;
    r.un  = un;
    r.inv = inv;
    r.inx = inx;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, expv, cycle);
    end
  endtask

  task automatic check_out(input string tag, input logic want_v, input exp_t e,
                           input logic v, input logic [63:0] r, input logic ov,
                           input logic un, input logic inv, input logic inx);
    check({tag, " out_valid"}, 64'(v), 64'(want_v));
    check({tag, " result"}, r, e.res);
    check({tag, " flags"}, 64'({ov, un, inv, inx}), 64'({e.ov, e.un, e.inv, e.inx}));
  endtask

  // Advance one clock, score both outputs, and drop the one-cycle input strobes.
  task automatic tick();
    logic was_rst;
    exp_t e;
    was_rst = rst;
    @(posedge clk);
    #1;
    cycle++;
    if (was_rst) begin
      q16.delete();
      q32.delete();
      last16 = '{default: 0};
      last32 = '{default: 0};
    end
    if (q16.size() > 0 && q16[0].due == cycle) begin
      e = q16.pop_front();
      last16 = e;
      check_out("h16", 1'b1, e, v16, 64'(res16), ovf16, un16, inv16, inx16);
    end else begin
      check_out("h16 idle", 1'b0, last16, v16, 64'(res16), ovf16, un16, inv16, inx16);
    end
    if (q32.size() > 0 && q32[0].due == cycle) begin
      e = q32.pop_front();
      last32 = e;
      check_out("s32", 1'b1, e, v32, 64'(res32), ovf32, un32, inv32, inx32);
    end else begin
      check_out("s32 idle", 1'b0, last32, v32, 64'(res32), ovf32, un32, inv32, inx32);
    end
    iv16 = 1'b0;
    iv32 = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input exp_t e);
    exp_t t;
    iv16  = 1'b1;
    a16   = x;
    b16   = y;
    sub16 = s;
    t     = e;
    t.due = cycle + 5;
    q16.push_back(t);
  endtask

  task automatic issue32(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input exp_t e);
    exp_t t;
    iv32  = 1'b1;
    a32   = x;
    b32   = y;
    sub32 = s;
    t     = e;
    t.due = cycle + 5;
    q32.push_back(t);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [31:0] wa, wb;
    logic        rs;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic add/sub and 4-cycle latency
    issue16(16'h3C00, 16'h4000, 1'b0, mk(64'h4200, 0, 0, 0, 0)); tick();
    repeat (5) tick();
    issue16(16'h3C00, 16'h4000, 1'b1, mk(64'hBC00, 0, 0, 0, 0)); tick();
    issue16(16'h3C00, 16'h3C00, 1'b1, mk(64'h0000, 0, 0, 0, 0)); tick();
    repeat (5) tick();

    // Back-to-back stream
    issue16(16'h3C00, 16'h4000, 1'b0, mk(64'h4200, 0, 0, 0, 0)); tick();
    issue16(16'h4000, 16'h4000, 1'b0, mk(64'h4400, 0, 0, 0, 0)); tick();
    issue16(16'h3C00, 16'h3C00, 1'b1, mk(64'h0000, 0, 0, 0, 0)); tick();

    // Rounding ties, overflow, underflow, subnormal flush, zero signs
    issue16(16'h3C00, 16'h1000, 1'b0, mk(64'h3C00, 0, 0, 0, 1)); tick();
    issue16(16'h3C01, 16'h1000, 1'b0, mk(64'h3C02, 0, 0, 0, 1)); tick();
    issue16(16'h7BFF, 16'h7BFF, 1'b0, mk(64'h7C00, 1, 0, 0, 1)); tick();
    issue16(16'h0401, 16'h0400, 1'b1, mk(64'h0000, 0, 1, 0, 1)); tick();
    issue16(16'h03FF, 16'h3C00, 1'b0, mk(64'h3C00, 0, 0, 0, 0)); tick();
    issue16(16'h8000, 16'h8000, 1'b0, mk(64'h8000, 0, 0, 0, 0)); tick();
    issue16(16'hBC00, 16'h3C00, 1'b0, mk(64'h0000, 0, 0, 0, 0)); tick();

    // Specials
    issue16(16'h7C00, 16'hFC00, 1'b0, mk(64'h7E00, 0, 0, 1, 0)); tick();
    issue16(16'h7E00, 16'h3C00, 1'b0, mk(64'h7E00, 0, 0, 1, 0)); tick();
    issue16(16'h7C00, 16'h3C00, 1'b0, mk(64'h7C00, 0, 0, 0, 0)); tick();
    issue16(16'h3C00, 16'h7C00, 1'b1, mk(64'hFC00, 0, 0, 0, 0)); tick();
    repeat (6) tick();

    // Reset mid-flight: nothing issued before or with the reset edge may emerge
    issue16(16'h3C00, 16'h4000, 1'b0, mk(64'h4200, 0, 0, 0, 0)); tick();
    issue16(16'h4000, 16'h4000, 1'b0, mk(64'h4400, 0, 0, 0, 0)); tick();
    rst = 1'b1;
    issue16(16'h4400, 16'h3C00, 1'b0, mk(64'h4500, 0, 0, 0, 0)); tick();
    rst = 1'b0;
    repeat (6) tick();
    issue16(16'h3C00, 16'h4000, 1'b0, mk(64'h4200, 0, 0, 0, 0)); tick();
    repeat (5) tick();

    // Single precision directed
    issue32(32'h3F800000, 32'h40000000, 1'b0, mk(64'h40400000, 0, 0, 0, 0)); tick();
    issue32(32'h3F800000, 32'h33800000, 1'b0, mk(64'h3F800000, 0, 0, 0, 1)); tick();
    issue32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, mk(64'h7F800000, 1, 0, 0, 1)); tick();
    repeat (5) tick();

    // Random traffic with bubbles against the reference model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) != 0) begin
        ra = 16'($urandom);
        rb = $urandom_range(1) ? 16'($urandom)
                               : {1'($urandom), ra[14:0] ^ 15'($urandom_range(0, 16'h0FFF))};
        rs = 1'($urandom);
        issue16(ra, rb, rs, ref_fp(5, 10, 64'(ra), 64'(rb), rs));
      end
      if ($urandom_range(1) != 0) begin
        wa = $urandom;
        wb = $urandom_range(1) ? 32'($urandom)
                               : {1'($urandom), wa[30:0] ^ 31'($urandom & 32'h01FF_FFFF)};
        rs = 1'($urandom);
        issue32(wa, wb, rs, ref_fp(8, 23, 64'(wa), 64'(wb), rs));
      end
      tick();
    end
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor.
- Next-generation successor to the keypad-driven 16-bit FP adder.
- Accepts one operand pair per cycle under a valid strobe and returns a rounded result after a fixed latency, with status flags.
- Sits between the operand-entry logic (keypad/switch front end) and the result display/LED logic. It replaces the ad-hoc sequential capture with a clean streaming interface.

Parameters:
- EXP_W, 5, exponent field width (bits); bias = 2^(EXP_W-1)-1.
- MAN_W, 10, stored fraction width (bits); hidden bit is implicit.
- W, EXP_W+MAN_W+1, total word width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock; one clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid this cycle.
- a  in  W  operand A {sign, exp, frac}.
- b  in  W  operand B.
- sub  in  1  0 = A+B, 1 = A-B (B sign inverted at stage 1).
- out_valid  out  1  result valid.
- result  out  W  rounded result.
- over  out  1  overflow: result forced to ±Inf.
- under  out  1  underflow: nonzero result flushed to ±0.
- invalid  out  1  invalid operation (NaN input, or Inf-Inf).
- inexact  out  1  rounding discarded nonzero bits.

Behaviour:
- Reset:
  - When rst=1 at a clock edge, every pipeline valid bit clears.
  - After that edge: out_valid=0, result=0, over=under=invalid=inexact=0.
  - In-flight operations are discarded; no partial result ever appears.
- Throughput and latency:
  - 1 operation per cycle; no backpressure.
  - Latency is exactly 4 cycles: in_valid at edge N produces out_valid=1 with result during the cycle after edge N+4.
  - Outputs and flags hold their last values while out_valid=0. Flags are meaningful only when out_valid=1.
- Stage 1 (unpack/align):
  - Effective B sign = b.sign XOR sub.
  - exp==0 is treated as zero (subnormals flushed, sign kept).
  - exp==all-ones is treated as Inf (frac==0) or NaN.
  - Swap so the larger magnitude is the "big" operand.
  - Shift the small mantissa right by the exponent difference into a MAN_W+4 field: {hidden, frac, guard, round, sticky}. Every bit shifted out ORs into sticky.
  - Shift amounts ≥ MAN_W+3 leave only sticky.
- Stage 2 (add/sub):
  - Magnitude add if signs are equal, otherwise big minus small. This never goes negative because of the swap.
  - MAN_W+5-bit result including carry.
  - Result sign = sign of big operand.
- Stage 3 (normalize):
  - On carry: shift right 1 (sticky preserved) and exponent +1.
  - Otherwise: leading-zero count and left shift until hidden=1; exponent minus the count.
  - Zero magnitude: result is exact zero.
- Stage 4 (round/pack/flags):
  - Round to nearest, ties to even, using guard/round/sticky.
  - Mantissa carry-out on rounding: exponent +1.
  - Exponent ≥ all-ones: result ±Inf (exp all-ones, frac 0), over=1, inexact=1.
  - Exponent ≤ 0 with nonzero magnitude: result ±0, under=1, inexact=1.
- Special-case priority (highest first):
  1. Any NaN input, or Inf + (-Inf) effective: canonical qNaN {0, all-ones, 1, 0...}, invalid=1.
  2. Any Inf input: that Inf.
  3. Normal path.
- Zero signs:
  - x + (-x) exact zero: +0.
  - (-0) + (-0): -0.
  - One zero operand: result is the other operand, exactly.
- Flags are per-result, not sticky; each is cleared on a result that does not raise it.
- in_valid=0 cycles insert bubbles: out_valid=0 in the corresponding output cycle.

Test Plan:
- Basic and latency (defaults, half precision): a=0x3C00, b=0x4000, sub=0 → 4 cycles later result=0x4200, all flags 0. Same operands with sub=1 → 0xBC00.
- Cancellation and back-to-back: a=0x3C00, b=0x3C00, sub=1 → 0x0000. Stream 3 pairs on consecutive cycles (1+2, 2+2, 1-1) → 0x4200, 0x4400, 0x0000 on 3 consecutive out_valid cycles.
- Rounding: 0x3C00+0x1000 → 0x3C00, inexact=1 (tie to even down). 0x3C01+0x1000 → 0x3C02, inexact=1 (tie to even up).
- Overflow/underflow/FTZ: 0x7BFF+0x7BFF → 0x7C00, over=1. 0x0401-0x0400 → 0x0000, under=1. Input 0x03FF (subnormal) + 0x3C00 → 0x3C00.
- Specials: 0x7C00 + 0xFC00 → 0x7E00, invalid=1. 0x7E00 + 0x3C00 → 0x7E00, invalid=1. 0x7C00 + 0x3C00 → 0x7C00, flags 0.
- Reset mid-flight: issue 3 valid pairs, assert rst for 1 cycle after the 2nd → out_valid stays 0 for all three; the next pair issued after reset emerges correctly with 4-cycle latency. Also run EXP_W=8, MAN_W=23: 0x3F800000+0x40000000 → 0x40400000.
